gth_rx_edge_capture: RTL and testbench
======================================

// Module: gth_rx_edge_capture
// PURPOSE
//  Receive side of the GTH probe link: consumes 32-bit parallel words from the GTH RX user data
//  path (rx usrclk domain, ref_clk_fb) and measures the bit offset from an arm pulse to the first
//  0->1 transition of the returned step. The result is a time-of-flight count in UI, handed to the
//  MCU over a valid/ready handshake. It sits between gtwiz_userdata_rx_out and ZCU104_MCU.
// PARAMETERS
//  DATA_W         32    RX word width; bit 0 is the first bit received on the line
//  TIMEOUT_WORDS  1024  valid words searched before giving up; >= 2
//  CNT_W          16    result width; 2**CNT_W > TIMEOUT_WORDS*DATA_W
// PORTS
//  ref_clk_fb      in   1       RX user clock; the only clock
//  reset           in   1       synchronous, active-high reset
//  rx_data         in   DATA_W  GTH RX parallel word
//  rx_valid        in   1       rx_data qualifier (RX reset done / userclk active)
//  arm             in   1       single-cycle start pulse from MCU (triger)
//  busy            out  1       high from accepted arm until result handshake completes
//  result_offset   out  CNT_W   UI offset of the first rising edge; all-ones on timeout
//  result_timeout  out  1       qualifies result: no edge within TIMEOUT_WORDS
//  result_valid    out  1       result available
//  result_ready    in   1       MCU accepts the result
// BEHAVIOUR
//  - Clocking: one clock, ref_clk_fb. Reset is synchronous and active-high on the port named reset.
//  - Reset: state=IDLE; busy, result_valid and result_timeout = 0; result_offset = 0; all internal
//    registers cleared. A reset mid-operation aborts the capture with no result produced.
//  - Input stage: rx_data/rx_valid registered once (d_r, v_r). All detection uses the registered copy.
//  - FSM states:
//    IDLE -> SEARCH when arm=1: word_cnt=0, prev_bit=1, busy=1. This blocks an edge at offset 0
//      when the line is already high; a low bit must be seen first.
//    SEARCH, on each cycle with v_r=1: for bit i, e(i) = d_r[i] & ~(i==0 ? prev_bit : d_r[i-1]).
//      If any e(i)=1: take the lowest i; result_offset = word_cnt*DATA_W + i; result_timeout=0;
//      result_valid=1; next state DONE.
//      Otherwise, if word_cnt==TIMEOUT_WORDS-1: result_offset=all-ones, result_timeout=1,
//      result_valid=1, next state DONE.
//      Otherwise: word_cnt+1, and prev_bit = d_r[DATA_W-1].
//      When v_r=0, word_cnt and prev_bit hold. Invalid words do not count toward the offset or
//      the timeout.
//    DONE: outputs held stable until result_valid & result_ready. In that cycle the FSM clears
//      result_valid and busy and moves to IDLE.
//  - Latency: result_valid rises on the 2nd ref_clk_fb edge after the word containing the edge is
//    presented with rx_valid=1.
//  - arm is ignored in SEARCH and DONE. This includes arm in the same cycle as the DONE handshake:
//    the MCU must re-issue arm once busy=0.
//  - Multiple edges in one word: the lowest index wins. An edge that spans words (prev bit31=0,
//    next bit0=1) reports offset word_cnt*DATA_W.
//  - Arithmetic is unsigned; word_cnt width is $clog2(TIMEOUT_WORDS); offset math is done in CNT_W.
// CONFIGURATION
//  GTH_RX_POLARITY_INV_EN: if defined, d_r is bitwise inverted before edge detection, for inverted
//    comparator/lane polarity. The block then reports the first 1->0 transition on the raw line,
//    and prev_bit still initialises to 1 after the inversion.
//    If not defined, the data path is used as received.
// TESTING
//  1 arm; words 0x00000000, 0x00000000, 0x00010000 -> result_offset=80, result_timeout=0, valid 2 clk after word 3
//  2 arm; words 0xFFFFFFFF, 0x00000000, 0x00000001 -> offset=64 (no edge at 0); then 0x00000000, 0x00000001 -> offset=32
//  3 arm; word 0x00F000F0 -> offset=4 (lowest edge wins); word 0x80000000 after 0x00000000 -> offset=63
//  4 TIMEOUT_WORDS=8; arm; 12 zero words -> after the 8th word: result_timeout=1, result_offset=0xFFFF
//  5 rerun test 1 with rx_valid=0 for 3 cycles between each word -> offset=80 unchanged
//  6 result_ready low 10 cycles -> outputs stable, arm ignored; reset mid-SEARCH -> next cycle busy=0, valid=0
//  7 with GTH_RX_POLARITY_INV_EN: arm; words 0xFFFFFFFF, 0xFFFEFFFF -> offset=48

Source files
------------

// File: rtl/gth_rx_edge_capture_if.sv
// Handshake/data bundle between the GTH RX user data path, the edge-capture block and the MCU.
// The master side drives RX data, arm and result_ready; the slave side is the capture block.
interface gth_rx_edge_capture_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              arm;
  logic              busy;
  logic [CNT_W-1:0]  result_offset;
  logic              result_timeout;
  logic              result_valid;
  logic              result_ready;

  modport master (
    output rx_data, rx_valid, arm, result_ready,
    input  busy, result_offset, result_timeout, result_valid
  );

  modport slave (
    input  rx_data, rx_valid, arm, result_ready,
    output busy, result_offset, result_timeout, result_valid
  );
endinterface

// File: rtl/gth_rx_edge_capture.sv
// Measures the UI offset from an arm pulse to the first 0->1 step on the GTH RX word stream.
// Optional macro GTH_RX_POLARITY_INV_EN inverts the registered word to detect 1->0 on the raw line.
module gth_rx_edge_capture #(
  parameter int DATA_W        = 32,
  parameter int TIMEOUT_WORDS = 1024,
  parameter int CNT_W         = 16
) (
  input  logic                      ref_clk_fb,
  input  logic                      reset,
  gth_rx_edge_capture_if.slave      bus
);
  localparam int WC_W  = (TIMEOUT_WORDS > 1) ? $clog2(TIMEOUT_WORDS) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(TIMEOUT_WORDS - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  d_r_q;
  logic               v_r_q;
  logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
  logic               prev_bit_q, prev_bit_d;
  logic               busy_q, busy_d;
  logic               result_valid_q, result_valid_d;
  logic               result_timeout_q, result_timeout_d;
  logic [CNT_W-1:0]   result_offset_q, result_offset_d;

  logic [DATA_W-1:0]  data_eff;
  logic [DATA_W-1:0]  edges;
  logic               edge_any;
  logic [IDX_W-1:0]   edge_idx;

`ifdef GTH_RX_POLARITY_INV_EN
  assign data_eff = ~d_r_q;
`else
  assign data_eff = d_r_q;
`endif

  // Bit 0 compares against the last bit of the previous valid word (or the armed '1').
  assign edges    = data_eff & ~{data_eff[DATA_W-2:0], prev_bit_q};
  assign edge_any = |edges;

  always_comb begin
    edge_idx = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (edges[i]) edge_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d          = state_q;
    word_cnt_d       = word_cnt_q;
    prev_bit_d       = prev_bit_q;
    busy_d           = busy_q;
    result_valid_d   = result_valid_q;
    result_timeout_d = result_timeout_q;
    result_offset_d  = result_offset_q;
    case (state_q)
      IDLE: begin
        if (bus.arm) begin
          state_d    = SEARCH;
          word_cnt_d = '0;
          prev_bit_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      SEARCH: begin
        if (v_r_q) begin
          if (edge_any) begin
            result_offset_d  = CNT_W'(word_cnt_q) * CNT_W'(DATA_W) + CNT_W'(edge_idx);
            result_timeout_d = 1'b0;
            result_valid_d   = 1'b1;
            state_d          = DONE;
          end else if (word_cnt_q == LAST_WORD) begin
            result_offset_d  = '1;
            result_timeout_d = 1'b1;
            result_valid_d   = 1'b1;
            state_d          = DONE;
          end else begin
            word_cnt_d = word_cnt_q + WC_W'(1);
            prev_bit_d = data_eff[DATA_W-1];
          end
        end
      end
      DONE: begin
        // A coincident arm is dropped here; the MCU re-arms once busy falls.
        if (bus.result_ready) begin
          result_valid_d = 1'b0;
          busy_d         = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ref_clk_fb) begin
    if (reset) begin
      state_q          <= IDLE;
      d_r_q            <= '0;
      v_r_q            <= 1'b0;
      word_cnt_q       <= '0;
      prev_bit_q       <= 1'b0;
      busy_q           <= 1'b0;
      result_valid_q   <= 1'b0;
      result_timeout_q <= 1'b0;
      result_offset_q  <= '0;
    end else begin
      state_q          <= state_d;
      d_r_q            <= bus.rx_data;
      v_r_q            <= bus.rx_valid;
      word_cnt_q       <= word_cnt_d;
      prev_bit_q       <= prev_bit_d;
      busy_q           <= busy_d;
      result_valid_q   <= result_valid_d;
      result_timeout_q <= result_timeout_d;
      result_offset_q  <= result_offset_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_timeout = result_timeout_q;
  assign bus.result_offset  = result_offset_q;
endmodule

// File: tb/tb_gth_rx_edge_capture.sv
// Directed bench for gth_rx_edge_capture: a vector table of word sequences plus hand sequences
// for timeout, back-pressure, arm-during-handshake and mid-search reset.
module tb_gth_rx_edge_capture;
  logic clk;
  logic reset;

`ifdef GTH_RX_POLARITY_INV_EN
  localparam logic [31:0] INV_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] INV_MASK = 32'h0000_0000;
`endif

  gth_rx_edge_capture_if #(.DATA_W(32), .CNT_W(16)) bus_if ();

  gth_rx_edge_capture #(.DATA_W(32), .TIMEOUT_WORDS(8), .CNT_W(16)) dut (
    .ref_clk_fb (clk),
    .reset      (reset),
    .bus        (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          nwords;
    logic [31:0] w [8];
    int          gap;
    logic [15:0] exp_off;
    logic        exp_to;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic arm_pulse();
    @(negedge clk);
    bus_if.arm = 1'b1;
    @(negedge clk);
    bus_if.arm = 1'b0;
  endtask

  task automatic drive_word(input logic [31:0] w, input int gap);
    for (int g = 0; g < gap; g++) begin
      bus_if.rx_valid = 1'b0;
      @(negedge clk);
    end
    bus_if.rx_data  = w ^ INV_MASK;
    bus_if.rx_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic handshake(input string name);
    bus_if.result_ready = 1'b1;
    @(negedge clk);
    bus_if.result_ready = 1'b0;
    chk({name, ".hs_valid"}, 32'(bus_if.result_valid), 32'd0);
    chk({name, ".hs_busy"}, 32'(bus_if.busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{"t1_80",       3, '{32'h0, 32'h0, 32'h0001_0000, 0, 0, 0, 0, 0}, 0, 16'd80, 1'b0};
    vecs[1] = '{"t2_no_edge0", 3, '{32'hFFFF_FFFF, 32'h0, 32'h0000_0001, 0, 0, 0, 0, 0}, 0, 16'd64, 1'b0};
    vecs[2] = '{"t2_32",       2, '{32'h0, 32'h0000_0001, 0, 0, 0, 0, 0, 0}, 0, 16'd32, 1'b0};
    vecs[3] = '{"t3_lowest",   1, '{32'h00F0_00F0, 0, 0, 0, 0, 0, 0, 0}, 0, 16'd4, 1'b0};
    vecs[4] = '{"t3_63",       2, '{32'h0, 32'h8000_0000, 0, 0, 0, 0, 0, 0}, 0, 16'd63, 1'b0};
    vecs[5] = '{"t5_gaps",     3, '{32'h0, 32'h0, 32'h0001_0000, 0, 0, 0, 0, 0}, 3, 16'd80, 1'b0};
    vecs[6] = '{"bit1",        1, '{32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0, 0}, 0, 16'd1, 1'b0};
    vecs[7] = '{"span",        2, '{32'h7FFF_FFFF, 32'h0000_0003, 0, 0, 0, 0, 0, 0}, 0, 16'd32, 1'b0};
    vecs[8] = '{"last_word",   8, '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8000_0000}, 0, 16'd255, 1'b0};
    // Raw FFFFFFFF, FFFEFFFF in the inverted-polarity build.
    vecs[9] = '{"t7_48",       2, '{32'h0, 32'h0001_0000, 0, 0, 0, 0, 0, 0}, 0, 16'd48, 1'b0};

    reset = 1'b1;
    bus_if.rx_data = '0;
    bus_if.rx_valid = 1'b0;
    bus_if.arm = 1'b0;
    bus_if.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_valid", 32'(bus_if.result_valid), 32'd0);
    chk("rst_timeout", 32'(bus_if.result_timeout), 32'd0);
    chk("rst_offset", 32'(bus_if.result_offset), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      arm_pulse();
      chk({vecs[v].name, ".busy"}, 32'(bus_if.busy), 32'd1);
      for (int k = 0; k < vecs[v].nwords; k++) begin
        drive_word(vecs[v].w[k], vecs[v].gap);
        chk({vecs[v].name, ".early_valid"}, 32'(bus_if.result_valid), 32'd0);
      end
      bus_if.rx_valid = 1'b0;
      @(negedge clk);
      chk({vecs[v].name, ".valid"}, 32'(bus_if.result_valid), 32'd1);
      chk({vecs[v].name, ".offset"}, 32'(bus_if.result_offset), 32'(vecs[v].exp_off));
      chk({vecs[v].name, ".timeout"}, 32'(bus_if.result_timeout), 32'(vecs[v].exp_to));
      $display("capture %s: offset=%0d timeout=%0b", vecs[v].name,
               bus_if.result_offset, bus_if.result_timeout);
      handshake(vecs[v].name);
    end

    // Timeout after the 8th valid word; surplus words while DONE are ignored.
    arm_pulse();
    for (int k = 0; k < 8; k++) begin
      drive_word(32'h0, 0);
      chk("to.early_valid", 32'(bus_if.result_valid), 32'd0);
    end
    drive_word(32'h0, 0);
    chk("to.valid", 32'(bus_if.result_valid), 32'd1);
    chk("to.timeout", 32'(bus_if.result_timeout), 32'd1);
    chk("to.offset", 32'(bus_if.result_offset), 32'h0000_FFFF);
    for (int k = 0; k < 3; k++) drive_word(32'h0000_0001, 0);
    bus_if.rx_valid = 1'b0;
    chk("to.hold_offset", 32'(bus_if.result_offset), 32'h0000_FFFF);
    $display("capture timeout: offset=%h timeout=%0b", bus_if.result_offset, bus_if.result_timeout);
    handshake("to");

    // Back-pressure: ready low for 10 cycles with an arm pulse in the middle.
    arm_pulse();
    drive_word(32'h0, 0);
    drive_word(32'h0, 0);
    drive_word(32'h0001_0000, 0);
    bus_if.rx_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus_if.arm = (c == 4);
      @(negedge clk);
      chk("bp.valid", 32'(bus_if.result_valid), 32'd1);
      chk("bp.offset", 32'(bus_if.result_offset), 32'd80);
      chk("bp.busy", 32'(bus_if.busy), 32'd1);
    end
    bus_if.arm = 1'b0;
    $display("capture backpressure: offset=%0d held 10 cycles", bus_if.result_offset);
    // Arm coincident with the handshake must not start a new capture.
    bus_if.arm = 1'b1;
    bus_if.result_ready = 1'b1;
    @(negedge clk);
    bus_if.arm = 1'b0;
    bus_if.result_ready = 1'b0;
    chk("hs_arm.busy0", 32'(bus_if.busy), 32'd0);
    @(negedge clk);
    chk("hs_arm.busy1", 32'(bus_if.busy), 32'd0);
    $display("capture arm_at_handshake: busy=%0b", bus_if.busy);

    // Reset in SEARCH aborts without producing a result.
    arm_pulse();
    drive_word(32'h0, 0);
    chk("rs.busy_before", 32'(bus_if.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_if.rx_valid = 1'b0;
    chk("rs.busy", 32'(bus_if.busy), 32'd0);
    chk("rs.valid", 32'(bus_if.result_valid), 32'd0);
    chk("rs.offset", 32'(bus_if.result_offset), 32'd0);
    @(negedge clk);
    chk("rs.valid_after", 32'(bus_if.result_valid), 32'd0);
    $display("capture reset_mid_search: busy=%0b valid=%0b", bus_if.busy, bus_if.result_valid);

    // Capture still works after the abort.
    arm_pulse();
    drive_word(32'h0, 0);
    drive_word(32'h0000_0100, 0);
    bus_if.rx_valid = 1'b0;
    @(negedge clk);
    chk("post_rs.valid", 32'(bus_if.result_valid), 32'd1);
    chk("post_rs.offset", 32'(bus_if.result_offset), 32'd40);
    $display("capture post_reset: offset=%0d", bus_if.result_offset);
    handshake("post_rs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
